// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and constants for the SPI frame receiver.
// Revision    : 1.0
// ============================================================================
package spi_pkg;
    typedef enum logic [2:0] {IDLE, SHIFT, DRAIN, DONE, ERR} spi_state_t;

    localparam int FRAME_BITS = 24;
    localparam int CNT_W      = 5;
endpackage
`default_nettype wire

// File: rtl/flopenr.sv
`default_nettype none
// ============================================================================
// Module      : flopenr
// Description : Enabled register with synchronous active-high reset to zero.
// Revision    : 1.0
// ============================================================================
module flopenr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    always_ff @(posedge clk) begin
        if (rst)
            o_q <= '0;
        else if (i_en)
            o_q <= i_d;
    end
endmodule
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_ff
// Description : Single-bit multi-stage synchronizer with synchronous reset.
// Revision    : 1.0
// ============================================================================
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (rst)
            r_chain <= {STAGES{RESET_VAL}};
        else
            r_chain <= {r_chain[STAGES-2:0], i_d};
    end

    assign o_q = r_chain[STAGES-1];
endmodule
`default_nettype wire

// File: rtl/spi_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : spi_frame_receiver
// Description : SPI mode-0 slave receiving 3-byte frames, length-checked.
// Revision    : 1.0
// ============================================================================
module spi_frame_receiver
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sck,
    input  logic       cs_n,
    input  logic       sdi,
    output logic [7:0] command,
    output logic [7:0] databyte1,
    output logic [7:0] databyte2,
    output logic       spi_done,
    output logic       frame_error
);
    localparam logic [CNT_W-1:0] c_frame_cnt   = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] c_overrun_cnt = CNT_W'(FRAME_BITS + 1);

    logic                  w_sck_s, w_cs_s, w_sdi_s;
    logic                  r_sck_d, r_cs_d;
    logic                  w_sck_rise, w_cs_fall, w_cs_rise;
    logic [SYNC_STAGES:0]  r_flush;
    logic                  r_armed;
    spi_state_t            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [FRAME_BITS-1:0] r_shift;
    logic                  w_commit;

    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst(reset), .i_d(sck), .o_q(w_sck_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(reset), .i_d(cs_n), .o_q(w_cs_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
        .clk(clk), .rst(reset), .i_d(sdi), .o_q(w_sdi_s)
    );

    assign w_sck_rise = w_sck_s & ~r_sck_d;
    assign w_cs_fall  = ~w_cs_s & r_cs_d;
    assign w_cs_rise  = w_cs_s & ~r_cs_d;
    assign w_commit   = (r_state == DONE) && (r_cnt == c_frame_cnt);

    // A frame may only start once cs_n has been seen high after the chains
    // flushed their reset values, so a frame already in flight at reset release
    // is never picked up halfway.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sck_d     <= 1'b0;
            r_cs_d      <= 1'b1;
            r_flush     <= '0;
            r_armed     <= 1'b0;
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            spi_done    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            r_sck_d     <= w_sck_s;
            r_cs_d      <= w_cs_s;
            r_flush     <= {r_flush[SYNC_STAGES-1:0], 1'b1};
            spi_done    <= 1'b0;
            frame_error <= 1'b0;
            if (r_flush[SYNC_STAGES] && w_cs_s)
                r_armed <= 1'b1;

            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_cs_fall && r_armed)
                        r_state <= SHIFT;
                end
                SHIFT: begin
                    if (w_cs_rise) begin
                        r_state <= DONE;
                    end else if (w_sck_rise) begin
                        r_shift <= {r_shift[FRAME_BITS-2:0], w_sdi_s};
                        if (r_cnt != c_overrun_cnt)
                            r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == c_frame_cnt)
                            r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_cs_rise)
                        r_state <= ERR;
                end
                DONE: begin
                    if (r_cnt == c_frame_cnt)
                        spi_done <= 1'b1;
                    else
                        frame_error <= 1'b1;
                    r_state <= IDLE;
                end
                ERR: begin
                    frame_error <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    flopenr #(.WIDTH(8)) u_cmd_reg (
        .clk(clk), .rst(reset), .i_en(w_commit), .i_d(r_shift[23:16]), .o_q(command)
    );
    flopenr #(.WIDTH(8)) u_db1_reg (
        .clk(clk), .rst(reset), .i_en(w_commit), .i_d(r_shift[15:8]), .o_q(databyte1)
    );
    flopenr #(.WIDTH(8)) u_db2_reg (
        .clk(clk), .rst(reset), .i_en(w_commit), .i_d(r_shift[7:0]), .o_q(databyte2)
    );
endmodule
`default_nettype wire

// File: tb/tb_spi_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_frame_receiver
// Description : Scoreboard bench for spi_frame_receiver (depth 2 and depth 3).
// Revision    : 1.0
// ============================================================================
module tb_spi_frame_receiver;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sck = 1'b0;
    logic cs_n = 1'b1;
    logic sdi = 1'b0;

    logic [7:0] command, databyte1, databyte2;
    logic       spi_done, frame_error;
    logic [7:0] command3, databyte13, databyte23;
    logic       spi_done3, frame_error3;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      name;
        bit         err;
        logic [7:0] c;
        logic [7:0] d1;
        logic [7:0] d2;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    spi_frame_receiver #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n), .sdi(sdi),
        .command(command), .databyte1(databyte1), .databyte2(databyte2),
        .spi_done(spi_done), .frame_error(frame_error)
    );

    spi_frame_receiver #(.SYNC_STAGES(3)) dut3 (
        .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n), .sdi(sdi),
        .command(command3), .databyte1(databyte13), .databyte2(databyte23),
        .spi_done(spi_done3), .frame_error(frame_error3)
    );

    // Monitor: every pulse on the depth-2 instance consumes one expectation.
    always @(negedge clk) begin
        if (spi_done || frame_error) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: got done=%0b err=%0b bytes=%h %h %h, expected no pulse",
                         spi_done, frame_error, command, databyte1, databyte2);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({spi_done, frame_error} !== {~e.err, e.err} ||
                    command !== e.c || databyte1 !== e.d1 || databyte2 !== e.d2) begin
                    bad++;
                    $display("FAIL %s: got done=%0b err=%0b bytes=%h %h %h, expected done=%0b err=%0b bytes=%h %h %h",
                             e.name, spi_done, frame_error, command, databyte1, databyte2,
                             ~e.err, e.err, e.c, e.d1, e.d2);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input string name, input bit err,
                        input logic [7:0] c, input logic [7:0] d1, input logic [7:0] d2);
        exp_t e;
        e.name = name; e.err = err; e.c = c; e.d1 = d1; e.d2 = d2;
        exp_q.push_back(e);
    endtask

    // MSB-first, sck = clk/8, sdi set up a full low phase before each rise.
    task automatic send_bits(input logic [31:0] d, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sdi = d[i];
            sck = 1'b0;
            cyc(4);
            sck = 1'b1;
            cyc(4);
        end
        sck = 1'b0;
    endtask

    task automatic start_frame();
        cs_n = 1'b0;
        cyc(6);
    endtask

    // Releases cs_n; optionally measures pulse latency on both depths.
    task automatic end_frame(input string name, input bit lat);
        int l2, l3;
        cyc(6);
        cs_n = 1'b1;
        if (lat) begin
            l2 = 0;
            l3 = 0;
            for (int k = 1; k <= 10; k++) begin
                @(posedge clk);
                #1;
                if ((spi_done || frame_error) && l2 == 0) l2 = k;
                if ((spi_done3 || frame_error3) && l3 == 0) l3 = k;
            end
            @(negedge clk);
            chk({name, "_lat_s2"}, 32'(l2), 32'd4);
            chk({name, "_lat_s3"}, 32'(l3), 32'd5);
        end else begin
            cyc(10);
        end
    endtask

    initial begin
        cyc(3);
        reset = 1'b0;
        cyc(2);
        chk("rst_command", {24'h0, command}, 32'h00);
        chk("rst_databyte1", {24'h0, databyte1}, 32'h00);
        chk("rst_databyte2", {24'h0, databyte2}, 32'h00);
        chk("rst_pulses", {30'h0, spi_done, frame_error}, 32'h0);
        cyc(5);

        push("good_a503ff", 1'b0, 8'hA5, 8'h03, 8'hFF);
        start_frame(); send_bits(32'hA503FF, 24); end_frame("good_a503ff", 1'b1);
        chk("good_s3_command", {24'h0, command3}, 32'hA5);

        push("short_23", 1'b1, 8'hA5, 8'h03, 8'hFF);
        start_frame(); send_bits(32'h5A5A5A, 23); end_frame("short_23", 1'b1);

        push("long_26", 1'b1, 8'hA5, 8'h03, 8'hFF);
        start_frame(); send_bits(32'h2AAAAAA, 26); end_frame("long_26", 1'b1);

        push("good_123456", 1'b0, 8'h12, 8'h34, 8'h56);
        start_frame(); send_bits(32'h123456, 24); end_frame("good_123456", 1'b1);

        // Reset in the middle of a frame; the tail must be discarded silently.
        start_frame(); send_bits(32'h3FF, 10);
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(1);
        chk("midrst_command", {24'h0, command}, 32'h00);
        chk("midrst_databyte2", {24'h0, databyte2}, 32'h00);
        send_bits(32'h1234, 14);
        end_frame("midrst_tail", 1'b0);
        chk("midrst_held", {8'h0, command, databyte1, databyte2}, 32'h0);

        push("good_deadbe", 1'b0, 8'hDE, 8'hAD, 8'hBE);
        start_frame(); send_bits(32'hDEADBE, 24); end_frame("good_deadbe", 1'b1);

        push("zero_bits", 1'b1, 8'hDE, 8'hAD, 8'hBE);
        start_frame(); end_frame("zero_bits", 1'b1);

        // Back-to-back frames with a 5-cycle cs_n high gap.
        push("b2b_first", 1'b0, 8'h11, 8'h22, 8'h33);
        push("b2b_second", 1'b0, 8'hC3, 8'h3C, 8'h81);
        start_frame(); send_bits(32'h112233, 24);
        cyc(6);
        cs_n = 1'b1;
        cyc(5);
        start_frame(); send_bits(32'hC33C81, 24); end_frame("b2b_second", 1'b1);

        cyc(5);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/spi_frame_receiver.md
# spi_frame_receiver

Receives 3-byte SPI frames from the MCU (SPI master, mode 0, MSB first) and presents them to `command_decoder` as `command`, `databyte1` and `databyte2`, with a one-cycle `spi_done` strobe. All SPI inputs are asynchronous to `clk`, so the block synchronizes and edge-detects them and validates frame length. A frame is committed only when chip-select deasserts after exactly 24 bits.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth for `sck`, `cs_n`, `sdi`; legal range ≥ 2.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sck`  in  1  SPI clock from the MCU; asynchronous.
- `cs_n`  in  1  SPI chip select, active-low; asynchronous.
- `sdi`  in  1  SPI data, master to FPGA; asynchronous.
- `command`  out  8  first byte of the last good frame.
- `databyte1`  out  8  second byte of the last good frame.
- `databyte2`  out  8  third byte of the last good frame.
- `spi_done`  out  1  one-cycle pulse; the three byte outputs are newly valid.
- `frame_error`  out  1  one-cycle pulse; the frame was rejected because its bit count was not 24.

## Operation
- Synchronizer chains:
  - `sck` chain resets to 0.
  - `cs_n` chain resets to 1.
  - `sdi` chain resets to 0.
  - One extra delay flop each on synced `sck` and synced `cs_n` for edge detection.
- Edge definitions, on synced signals:
  - `sck_rise` = synced `sck` high and previous value low.
  - `cs_fall` = synced `cs_n` low and previous value high.
  - `cs_rise` = synced `cs_n` high and previous value low.
- 24-bit shift register, shifting left; a bit enters at bit 0 on each counted `sck_rise`.
- 5-bit bit counter, saturating at 25.
- FSM states:
  - IDLE: counter cleared. `cs_fall` → SHIFT. All `sck_rise` ignored.
  - SHIFT: each `sck_rise` shifts in synced `sdi` and increments the counter. On `cs_rise` → DONE. When the counter reaches 25 (overrun) → DRAIN.
  - DRAIN: ignores `sck`. On `cs_rise` → ERR.
  - DONE: single cycle. If counter == 24, load the output registers from the shift register and pulse `spi_done`; otherwise pulse `frame_error` and leave the outputs unchanged. Then → IDLE.
  - ERR: single cycle. Pulse `frame_error`, then → IDLE.
- Byte mapping: `command` = shift[23:16], `databyte1` = shift[15:8], `databyte2` = shift[7:0].
- Output registers hold their values until the next good frame.

Boundary cases:
- Zero-bit frame (`cs_n` low then high with no `sck`): `frame_error`.
- Short frame (1–23 bits): `frame_error`; outputs unchanged.
- Long frame (≥ 25 bits): `frame_error`, pulsed once at `cs_rise`.
- `sck_rise` and `cs_rise` in the same cycle: `cs_rise` wins and that sck edge is not counted.
- `sck_rise` in the same cycle as `cs_fall`: ignored, because the FSM is still in IDLE.
- `reset` mid-frame: returns to IDLE and clears all outputs. The rest of that frame is discarded, because leaving IDLE requires a fresh `cs_fall`.
- If `cs_n` is already low when `reset` releases, the block stays in IDLE until `cs_n` goes high and then low again.

## Timing
- Reset values: `command`, `databyte1`, `databyte2` = 8'h00; `spi_done` = 0; `frame_error` = 0; FSM = IDLE; counter = 0.
- `sck` high and low phases must each be at least SYNC_STAGES+1 `clk` periods; with SYNC_STAGES = 2, `sck` ≤ clk/6.
- `cs_n` setup to the first `sck` rise and hold after the last `sck` rise: ≥ SYNC_STAGES+2 `clk` cycles each.
- `sdi` must be stable around the `sck` rise (mode 0). It is sampled from its own synchronizer of equal depth, so it is aligned with `sck_rise`.
- Latency: `spi_done` and the updated outputs appear SYNC_STAGES+2 `clk` cycles after the raw `cs_n` rising edge (synchronizer, edge flop, DONE cycle).
- Outputs are registered. `spi_done` is high for exactly one cycle per good frame, and the byte outputs are stable in that cycle and afterwards. This matches `command_decoder` latching on `spi_done`.
- Minimum `cs_n` high time between frames: SYNC_STAGES+3 `clk` cycles.

## Structure
- Shared package `spi_pkg`:
  - `typedef enum logic [2:0] {IDLE, SHIFT, DRAIN, DONE, ERR} spi_state_t`
  - `localparam FRAME_BITS = 24`
  - `localparam CNT_W = 5`
- Sub-module `sync_ff #(STAGES, RESET_VAL)`: single-bit synchronizer with synchronous reset to `RESET_VAL`, instantiated three times.
- Output byte registers use the existing `flopenr`, enabled by the DONE-cycle commit.

## Test plan
- Good frame: bytes 0xA5, 0x03, 0xFF, with `sck` = clk/8 → one `spi_done` pulse; `command` = 0xA5, `databyte1` = 0x03, `databyte2` = 0xFF; `frame_error` stays 0.
- Short frame of 23 bits after the good frame → one `frame_error` pulse, no `spi_done`, outputs still 0xA5/0x03/0xFF.
- 26-bit frame → exactly one `frame_error` pulse at `cs_n` release; outputs unchanged. A following good frame 0x12, 0x34, 0x56 is then received correctly.
- `reset` asserted after 10 bits with `cs_n` held low, and the remaining 14 bits sent → no `spi_done`, no `frame_error`, outputs 0x00. The next full frame decodes correctly.
- `cs_n` low with no `sck`, then high → single `frame_error`. Back-to-back good frames at the minimum `cs_n` high gap → two `spi_done` pulses with the correct bytes each time.
- Latency check with SYNC_STAGES = 3 → `spi_done` exactly 5 `clk` cycles after the raw `cs_n` rise.
